// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the traffic light controller timer
//               interface: timer state encoding, default counter width and
//               default prescaler ratio.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE   = 2'b00,
        TMR_COUNT  = 2'b01,
        TMR_EXPIRE = 2'b10
    } tmr_state_t;

    localparam int TIMER_W             = 4;
    localparam int DEFAULT_CLK_PER_SEC = 50_000_000;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running modulo-CLK_PER_SEC counter that advances only
//               while enabled and emits a one-cycle tick at terminal count.
// Ports       : clk  - system clock
//               rst  - asynchronous active-low reset
//               en   - advance enable; counter holds when low
//               clr  - synchronous clear, overrides en
//               tick - high for the cycle in which the count wraps
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              c_pw       = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [c_pw-1:0] c_terminal = c_pw'(CLK_PER_SEC - 1);

    logic [c_pw-1:0] r_cnt_q;
    logic [c_pw-1:0] w_cnt_d;
    logic            w_at_terminal;

    always_comb begin
        w_at_terminal = (r_cnt_q == c_terminal);
        w_cnt_d       = r_cnt_q;
        if (clr) begin
            w_cnt_d = '0;
        end else if (en) begin
            w_cnt_d = w_at_terminal ? '0 : r_cnt_q + 1'b1;
        end
    end

    // A clear in the terminal cycle suppresses the tick so a reload wins.
    assign tick = en && !clr && w_at_terminal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/traffic_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_interval_timer
// Description : Whole-second down counter for the traffic light controller.
//               Loads an interval, decrements once per CLK_PER_SEC enabled
//               cycles, and reports a one-cycle expiry pulse plus busy flag.
// Ports       : clk     - system clock
//               rst     - asynchronous active-low reset
//               en      - count enable (ignored outside COUNT)
//               load    - load init into the counter, highest priority
//               init    - interval length in seconds
//               out     - remaining seconds (registered)
//               expired - one-cycle pulse when out reaches 0 by counting
//               busy    - high while a nonzero interval is counting
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_interval_timer
    import traffic_pkg::*;
#(
    parameter int CLK_PER_SEC = DEFAULT_CLK_PER_SEC,
    parameter int WIDTH       = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    output logic [WIDTH-1:0] out,
    output logic             expired,
    output logic             busy
);

    tmr_state_t       r_state_q;
    tmr_state_t       w_state_d;
    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] w_out_d;
    logic             w_tick;
    logic             w_presc_en;

    // The prescaler only runs while an interval is actively counting.
    assign w_presc_en = en && (r_state_q == TMR_COUNT);

    tick_prescaler #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_presc_en),
        .clr  (load),
        .tick (w_tick)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_out_d   = r_out_q;
        if (load) begin
            w_out_d   = init;
            w_state_d = (init != '0) ? TMR_COUNT : TMR_IDLE;
        end else begin
            case (r_state_q)
                TMR_IDLE: begin
                    w_state_d = TMR_IDLE;
                end
                TMR_COUNT: begin
                    // COUNT implies out > 0; the guard keeps the decrement
                    // from ever wrapping even if state were corrupted.
                    if (w_tick && (r_out_q != '0)) begin
                        w_out_d = r_out_q - 1'b1;
                        if (r_out_q == WIDTH'(1)) begin
                            w_state_d = TMR_EXPIRE;
                        end
                    end
                end
                TMR_EXPIRE: begin
                    w_state_d = TMR_IDLE;
                end
                default: begin
                    w_state_d = TMR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= TMR_IDLE;
            r_out_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_out_q   <= w_out_d;
        end
    end

    assign out     = r_out_q;
    assign busy    = (r_state_q == TMR_COUNT);
    assign expired = (r_state_q == TMR_EXPIRE);

endmodule : traffic_interval_timer
`default_nettype wire

// File: tb/tb_traffic_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_interval_timer
// Description : Self-checking bench for traffic_interval_timer with
//               CLK_PER_SEC=4. Expected outputs are queued when stimulus is
//               applied and compared as the DUT produces each cycle's output.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_interval_timer;

    localparam int CPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] init;
    logic [3:0] out;
    logic       expired;
    logic       busy;

    typedef struct {
        logic [3:0] out;
        logic       expired;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    traffic_interval_timer #(
        .CLK_PER_SEC (CPS),
        .WIDTH       (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .init    (init),
        .out     (out),
        .expired (expired),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int o, input bit x, input bit b);
        exp_t r;
        r.out     = 4'(o);
        r.expired = x;
        r.busy    = b;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; load = 1'b0; init = 4'd0;
        sb_q.push_back(mk(0, 0, 0));
        repeat (3) cycle();
        e = sb_q.pop_front();
        checks++;
        if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
            errors++;
            $display("FAIL reset_init got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                     out, expired, busy, e.out, e.expired, e.busy);
        end
        rst = 1'b1;
        // Load 7 and count until one decrement has happened.
        load = 1'b1; init = 4'd7; en = 1'b1;
        sb_q.push_back(mk(6, 0, 1));
        cycle();
        load = 1'b0;
        repeat (5) cycle();
        e = sb_q.pop_front();
        checks++;
        if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
            errors++;
            $display("FAIL pre_reset got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                     out, expired, busy, e.out, e.expired, e.busy);
        end
        // Assert reset mid-cycle; outputs must clear before the next edge.
        #2 rst = 1'b0;
        sb_q.push_back(mk(0, 0, 0));
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
            errors++;
            $display("FAIL reset_async got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                     out, expired, busy, e.out, e.expired, e.busy);
        end
        cycle();
        rst = 1'b1;
        // en stays high but the block must remain idle without a load.
        for (int j = 0; j < 6; j++) sb_q.push_back(mk(0, 0, 0));
        for (int j = 0; j < 6; j++) begin
            cycle();
            e = sb_q.pop_front();
            checks++;
            if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
                errors++;
                $display("FAIL reset_idle j=%0d got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                         j, out, expired, busy, e.out, e.expired, e.busy);
            end
        end
    endtask

    // j counts edges after the load edge; decrements land every CPS edges.
    task automatic test_countdown(input int n, input string tag);
        int last;
        last = n * CPS + 2;
        load = 1'b1; init = 4'(n); en = 1'b1;
        for (int j = 0; j <= last; j++) begin
            sb_q.push_back(mk((j >= n * CPS) ? 0 : n - j / CPS,
                              (j == n * CPS), (j < n * CPS)));
        end
        cycle();
        load = 1'b0;
        for (int j = 0; j <= last; j++) begin
            e = sb_q.pop_front();
            checks++;
            if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
                errors++;
                $display("FAIL %s j=%0d got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                         tag, j, out, expired, busy, e.out, e.expired, e.busy);
            end
            cycle();
        end
    endtask

    // en high for edges 1-2, low for 3-12, high from 13: prescaler resumes
    // at 2, so the first decrement lands on edge 14.
    task automatic test_pause();
        load = 1'b1; init = 4'd2; en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            sb_q.push_back(mk((j < 14) ? 2 : (j < 18) ? 1 : 0, (j == 18), (j < 18)));
        end
        cycle();
        load = 1'b0;
        for (int j = 0; j < 20; j++) begin
            e = sb_q.pop_front();
            checks++;
            if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
                errors++;
                $display("FAIL pause j=%0d got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                         j, out, expired, busy, e.out, e.expired, e.busy);
            end
            en = ((j + 1) <= 2) || ((j + 1) >= 13);
            cycle();
        end
    endtask

    // Load 0 from idle, then load 9 and overwrite it with 0 mid-count.
    task automatic test_zero_load();
        en = 1'b1;
        for (int j = 0; j < 14; j++) begin
            sb_q.push_back((j == 6) ? mk(9, 0, 1) : mk(0, 0, 0));
        end
        for (int j = 0; j < 14; j++) begin
            load = (j == 0) || (j == 6) || (j == 7);
            init = (j == 6) ? 4'd9 : 4'd0;
            cycle();
            e = sb_q.pop_front();
            checks++;
            if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
                errors++;
                $display("FAIL zero_load j=%0d got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                         j, out, expired, busy, e.out, e.expired, e.busy);
            end
        end
        load = 1'b0;
    endtask

    // Reload on the terminal-decrement edge (at_edge=4) or during EXPIRE
    // (at_edge=5). Either way the new interval restarts with prescaler 0.
    task automatic test_reload(input int at_edge, input string tag);
        load = 1'b1; init = 4'd1; en = 1'b1;
        for (int j = 0; j < at_edge + 6; j++) begin
            if (j < 4)            sb_q.push_back(mk(1, 0, 1));
            else if (j < at_edge) sb_q.push_back(mk(0, 1, 0));
            else                  sb_q.push_back(mk((j < at_edge + 4) ? 5 : 4, 0, 1));
        end
        cycle();
        load = 1'b0;
        for (int j = 0; j < at_edge + 6; j++) begin
            e = sb_q.pop_front();
            checks++;
            if ({out, expired, busy} !== {e.out, e.expired, e.busy}) begin
                errors++;
                $display("FAIL %s j=%0d got out=%0d expired=%0b busy=%0b want out=%0d expired=%0b busy=%0b",
                         tag, j, out, expired, busy, e.out, e.expired, e.busy);
            end
            load = ((j + 1) == at_edge);
            init = 4'd5;
            cycle();
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown(3, "basic");
        test_pause();
        test_zero_load();
        test_reload(4, "reload_terminal");
        test_reload(5, "reload_expire");
        test_countdown(15, "max_value");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_traffic_interval_timer
`default_nettype wire
